// File: rtl/video_timing_if.sv
// Output bundle of the video timing counter: counters, address and flags.
// master drives (counter block), slave observes (CPU interface, shifter).
interface video_timing_if;
  logic [5:0]  h_count;
  logic [8:0]  v_count;
  logic [13:0] video_addr;
  logic        hblank;
  logic        vblank;
  logic        hsync;
  logic        vsync;
  logic        count240;
  logic        va11;
  logic        line_start;
  logic        frame_start;
  logic [7:0]  vcount_rd;

  modport master (
    output h_count, v_count, video_addr,
    output hblank, vblank, hsync, vsync,
    output count240, va11,
    output line_start, frame_start,
    output vcount_rd
  );

  modport slave (
    input h_count, v_count, video_addr,
    input hblank, vblank, hsync, vsync,
    input count240, va11,
    input line_start, frame_start,
    input vcount_rd
  );
endinterface

// File: rtl/video_timing_counter.sv
// Horizontal/vertical video counters advanced once per E cycle (en_e).
// Ports: clk, rst_n (async low), en_e; vt carries counters, address, flags.
module video_timing_counter #(
  parameter int H_TOTAL     = 64,
  parameter int H_ACTIVE    = 48,
  parameter int HSYNC_START = 52,
  parameter int HSYNC_END   = 56,
  parameter int V_TOTAL     = 260,
  parameter int V_ACTIVE    = 240,
  parameter int VSYNC_START = 248,
  parameter int VSYNC_END   = 252
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_e,
  video_timing_if.master vt
);

  if (!(H_ACTIVE < HSYNC_START &&
        HSYNC_START < HSYNC_END &&
        HSYNC_END <= H_TOTAL &&
        H_TOTAL <= 64)) begin : g_bad_h
    $error("video_timing_counter: illegal horizontal timing");
  end

  if (!(V_ACTIVE < VSYNC_START &&
        VSYNC_START < VSYNC_END &&
        VSYNC_END <= V_TOTAL &&
        V_TOTAL <= 512)) begin : g_bad_v
    $error("video_timing_counter: illegal vertical timing");
  end

  localparam logic [5:0] H_LAST = 6'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  // One extra bit so an end value equal to the total still compares.
  localparam logic [6:0] H_ACT = 7'(H_ACTIVE);
  localparam logic [6:0] HS_ST = 7'(HSYNC_START);
  localparam logic [6:0] HS_EN = 7'(HSYNC_END);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] VS_ST = 10'(VSYNC_START);
  localparam logic [9:0] VS_EN = 10'(VSYNC_END);

  logic [5:0] h_nxt;
  logic [8:0] v_nxt;
  logic [6:0] h_ext;
  logic [9:0] v_ext;

  always_comb begin
    h_nxt = vt.h_count + 6'd1;
    v_nxt = vt.v_count;
    if (vt.h_count == H_LAST) begin
      h_nxt = '0;
      if (vt.v_count == V_LAST) v_nxt = '0;
      else v_nxt = vt.v_count + 9'd1;
    end
  end

  assign h_ext = {1'b0, h_nxt};
  assign v_ext = {1'b0, v_nxt};

  // Flags decode the next counter values so they land on the same
  // edge as the counters themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vt.h_count     <= '0;
      vt.v_count     <= '0;
      vt.video_addr  <= '0;
      vt.hblank      <= 1'b0;
      vt.vblank      <= 1'b0;
      vt.hsync       <= 1'b0;
      vt.vsync       <= 1'b0;
      vt.count240    <= 1'b0;
      vt.va11        <= 1'b0;
      vt.line_start  <= 1'b0;
      vt.frame_start <= 1'b0;
      vt.vcount_rd   <= '0;
    end else begin
      vt.line_start  <= 1'b0;
      vt.frame_start <= 1'b0;
      if (en_e) begin
        vt.h_count    <= h_nxt;
        vt.v_count    <= v_nxt;
        vt.video_addr <= {v_nxt[7:0], h_nxt};
        vt.hblank     <= h_ext >= H_ACT;
        vt.hsync      <= (h_ext >= HS_ST) && (h_ext < HS_EN);
        vt.vblank     <= v_ext >= V_ACT;
        vt.vsync      <= (v_ext >= VS_ST) && (v_ext < VS_EN);
        vt.count240   <= v_ext >= V_ACT;
        vt.va11       <= v_nxt[5];
        if (h_nxt == '0) begin
          vt.line_start  <= 1'b1;
          vt.frame_start <= (v_nxt == '0);
          // Snapshot at line start only, so reads never tear mid-line.
          vt.vcount_rd   <= {v_nxt[7:2], 2'b00};
        end
      end
    end
  end

endmodule

// File: doc/video_timing_counter.md
Name: video_timing_counter

Overview:
- Consumes the E-phase enable from the clock generator and advances the horizontal/vertical video counters once per E cycle, at 1 byte-column per E.
- Produces registered blanking, sync, video address, and the count-240 and VA11 interrupt sources used by the CPU interface and video shifter.
- Sits directly downstream of the clock generator. Every state change is qualified by en_e.

Parameters:
- H_TOTAL, 64, E cycles per line (h_count wraps H_TOTAL-1 -> 0)
- H_ACTIVE, 48, first blanked column (hblank when h_count >= H_ACTIVE)
- HSYNC_START, 52, first column of hsync
- HSYNC_END, 56, first column after hsync
- V_TOTAL, 260, lines per frame (v_count wraps V_TOTAL-1 -> 0)
- V_ACTIVE, 240, first blanked line; also the count-240 threshold
- VSYNC_START, 248, first line of vsync
- VSYNC_END, 252, first line after vsync

Ports:
- clk  in  1  system clock, same domain as the clock generator
- rst_n  in  1  asynchronous, active-low reset
- en_e  in  1  one-clk enable, one pulse per E cycle; the only advance qualifier
- h_count  out  6  horizontal column counter
- v_count  out  9  vertical line counter
- video_addr  out  14  {v_count[7:0], h_count} display address for the shifter
- hblank  out  1  horizontal blank
- vblank  out  1  vertical blank
- hsync  out  1  horizontal sync, active high
- vsync  out  1  vertical sync, active high
- count240  out  1  level, high while v_count >= V_ACTIVE
- va11  out  1  level, equals v_count[5]; toggles every 32 lines
- line_start  out  1  one-clk pulse when h_count becomes 0
- frame_start  out  1  one-clk pulse when (v_count, h_count) becomes (0, 0)
- vcount_rd  out  8  CPU-readable counter: {v_count[7:2], 2'b00}, updated only when h_count becomes 0

Behaviour:
- Reset (async assert, deassert sampled on clk): h_count=0, v_count=0, video_addr=0, vcount_rd=0. All flags (hblank, vblank, hsync, vsync, count240, va11, line_start, frame_start) = 0.
- No en_e: every register holds its value. line_start and frame_start are forced to 0.
- On a clk edge with en_e=1:
  - h_count increments. At H_TOTAL-1 it wraps to 0 and v_count increments.
  - When v_count=V_TOTAL-1 and h_count wraps, v_count wraps to 0.
- Decode timing: all flag outputs are registered and computed from the next counter values. Flags therefore change on the same edge as the counters, with zero lag relative to h_count/v_count.
- hblank = (h >= H_ACTIVE)
- hsync = (HSYNC_START <= h < HSYNC_END)
- vblank = (v >= V_ACTIVE)
- vsync = (VSYNC_START <= v < VSYNC_END)
- count240 = (v >= V_ACTIVE)
- va11 = v[5]
- line_start: high exactly for the clk following the edge where h_count became 0.
- frame_start: additionally requires v_count to have become 0.
- vcount_rd loads on the line_start edge only, so the CPU never sees a mid-line tear.
- Widths: v_count is 9 bits because V_TOTAL > 256. video_addr uses only v_count[7:0], so lines 256..259 alias 0..3 (these lines are always blanked).
- Back-to-back en_e (every clk) is legal; the counters advance every clk.
- Reset mid-line: all state clears immediately, with no partial-line completion.
- Parameter legality, checked by an elaboration-time assertion:
  - H_ACTIVE < HSYNC_START < HSYNC_END <= H_TOTAL <= 64
  - V_ACTIVE < VSYNC_START < VSYNC_END <= V_TOTAL <= 512

Test Plan:
- Reset then 64 en_e pulses spaced 12 clk apart -> h_count runs 0..63 then returns to 0, v_count=1, one line_start pulse, vcount_rd stays 0.
- en_e every clk for 64*260=16640 pulses -> v_count returns to 0 and h_count=0. Exactly one frame_start pulse, 260 line_start pulses, vsync high for 4*64=256 en_e cycles.
- Step to v_count=239, h_count=63, then one en_e -> same edge: v_count=240, count240=1, vblank=1, hblank=0.
- Step to h_count=51 then one en_e -> hsync=1 at h_count=52. Four more en_e -> hsync=0 at h_count=56. hblank=1 throughout h_count 48..63.
- Hold en_e=0 for 1000 clk mid-line (h_count=20, v_count=100) -> all outputs unchanged, line_start=0, frame_start=0.
- Assert rst_n=0 asynchronously between clk edges at v_count=250 -> outputs read 0 before the next clk edge. After release, the first en_e gives h_count=1 and v_count=0.
